// File: rtl/pipe_skid_chain.sv
// Chain of STAGES valid/ready register stages, each either a 2-entry skid buffer
// with a registered ready (SKID=1) or a single register with pass-through ready (SKID=0).
module pipe_skid_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int SKID       = 1,
  localparam int CAP       = STAGES * (1 + SKID),
  localparam int OCC_W     = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy
);

  logic                  run_q;
  logic [STAGES-1:0]     m_vld;
  logic [DATA_WIDTH-1:0] m_data [STAGES];
  logic [STAGES-1:0]     vin;
  logic [DATA_WIDTH-1:0] din    [STAGES];
  // rdn[i] is the ready offered to stage i-1; rdn[STAGES] comes from downstream
  logic [STAGES:0]       rdn;
  logic                  in_xfer;
  logic                  out_xfer;

  always_comb begin
    vin[0] = in_valid & run_q & ~flush;
    din[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      vin[i] = m_vld[i-1];
      din[i] = m_data[i-1];
    end
  end

  assign in_ready  = rdn[0] & run_q & ~flush;
  assign out_valid = m_vld[STAGES-1] & ~flush;
  assign out_data  = m_data[STAGES-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Holds in_ready low through the first edge after reset release in both modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     occupancy <= '0;
    else if (flush) occupancy <= '0;
    else            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

  if (SKID != 0) begin : g_skid
    logic [STAGES-1:0]     s_vld;
    logic [STAGES-1:0]     rdy_q;
    logic [STAGES-1:0]     m_nxt;
    logic [STAGES-1:0]     s_nxt;
    logic [STAGES-1:0]     ld_skid;
    logic [STAGES-1:0]     ld_in;
    logic [STAGES-1:0]     park;
    logic [DATA_WIDTH-1:0] s_data [STAGES];

    assign rdn = {out_ready & ~flush, rdy_q};

    // Main entry refills from skid first; a beat arriving while main is stuck parks in skid
    always_comb begin
      m_nxt   = m_vld;
      s_nxt   = s_vld;
      ld_skid = '0;
      ld_in   = '0;
      park    = '0;
      for (int i = 0; i < STAGES; i++) begin
        if (!m_vld[i] || rdn[i+1]) begin
          if (s_vld[i]) begin
            ld_skid[i] = 1'b1;
            m_nxt[i]   = 1'b1;
            s_nxt[i]   = 1'b0;
          end else begin
            ld_in[i] = vin[i] & rdy_q[i];
            m_nxt[i] = vin[i] & rdy_q[i];
          end
        end else if (vin[i] && rdy_q[i]) begin
          park[i]  = 1'b1;
          s_nxt[i] = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_vld <= '0;
        s_vld <= '0;
        rdy_q <= '0;
      end else if (flush) begin
        m_vld <= '0;
        s_vld <= '0;
        rdy_q <= '1;
      end else begin
        m_vld <= m_nxt;
        s_vld <= s_nxt;
        rdy_q <= ~s_nxt;
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld_skid[i])   m_data[i] <= s_data[i];
        else if (ld_in[i]) m_data[i] <= din[i];
        if (park[i])      s_data[i] <= din[i];
      end
    end
  end else begin : g_reg
    // Ready ripples back from the output through every empty-or-draining stage
    always_comb begin
      rdn[STAGES] = out_ready & ~flush;
      for (int i = STAGES - 1; i >= 0; i--) begin
        rdn[i] = ~m_vld[i] | rdn[i+1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_vld <= '0;
      end else if (flush) begin
        m_vld <= '0;
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          if (vin[i] && rdn[i]) m_vld[i] <= 1'b1;
          else if (rdn[i+1])    m_vld[i] <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
        if (vin[i] && rdn[i]) m_data[i] <= din[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Scoreboard bench for pipe_skid_chain: three configurations share one stimulus stream,
// each with its own expected-beat queue and occupancy model.
module tb_pipe_skid_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
  logic [7:0] out_data_a, out_data_b, out_data_c;
  logic [2:0] occ_a;
  logic       occ_b;
  logic [1:0] occ_c;

  // a: STAGES=3 SKID=1, b: STAGES=1 SKID=0, c: STAGES=3 SKID=0
  pipe_skid_chain #(.DATA_WIDTH(8), .STAGES(3), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .occupancy(occ_a));
  pipe_skid_chain #(.DATA_WIDTH(8), .STAGES(1), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .occupancy(occ_b));
  pipe_skid_chain #(.DATA_WIDTH(8), .STAGES(3), .SKID(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .occupancy(occ_c));

  logic [2:0] irdy, ovld;
  logic [7:0] odat [3];
  logic [3:0] occw [3];
  assign irdy    = {in_ready_c, in_ready_b, in_ready_a};
  assign ovld    = {out_valid_c, out_valid_b, out_valid_a};
  assign odat[0] = out_data_a;
  assign odat[1] = out_data_b;
  assign odat[2] = out_data_c;
  assign occw[0] = 4'(occ_a);
  assign occw[1] = 4'(occ_b);
  assign occw[2] = 4'(occ_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec, n_err;
  int         cnt [3];
  int         nacc [3];
  bit         hold [3];
  logic [7:0] hdat [3];
  logic [7:0] q0[$], q1[$], q2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void sb_push(int k, logic [7:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [7:0] sb_pop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int sb_size(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void sb_clear(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Called at the falling edge: what is visible now is what the next rising edge commits.
  task automatic mon();
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sb_clear(k);
        cnt[k]  = 0;
        hold[k] = 1'b0;
      end else begin
        chk($sformatf("occ%0d", k), 32'(occw[k]), cnt[k]);
        if (flush) begin
          chk($sformatf("flush_irdy%0d", k), 32'(irdy[k]), 0);
          chk($sformatf("flush_ovld%0d", k), 32'(ovld[k]), 0);
          sb_clear(k);
          cnt[k]  = 0;
          hold[k] = 1'b0;
        end else begin
          if (hold[k]) begin
            chk($sformatf("hold_vld%0d", k), 32'(ovld[k]), 1);
            chk($sformatf("hold_dat%0d", k), 32'(odat[k]), 32'(hdat[k]));
          end
          if (ovld[k] && out_ready) begin
            if (sb_size(k) == 0) begin
              chk($sformatf("out_unexpected%0d", k), 32'(ovld[k]), 0);
            end else begin
              e = sb_pop(k);
              chk($sformatf("out_data%0d", k), 32'(odat[k]), 32'(e));
            end
            cnt[k]--;
          end
          if (in_valid && irdy[k]) begin
            sb_push(k, in_data);
            cnt[k]++;
            nacc[k]++;
          end
          hold[k] = ovld[k] && !out_ready;
          hdat[k] = odat[k];
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      next();
    end
  endtask

  int nout, nin, orate, vrate, cyc;

  initial begin
    n_vec = 0; n_err = 0;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; nacc[k] = 0; hold[k] = 1'b0; hdat[k] = '0;
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ovld%0d", k), 32'(ovld[k]), 0);
      chk($sformatf("rst_occ%0d", k), 32'(occw[k]), 0);
      chk($sformatf("rst_irdy%0d", k), 32'(irdy[k]), 0);
    end
    next();
    next();
    rst_n = 1'b1;
    idle(1);
    sample();
    for (int k = 0; k < 3; k++) chk($sformatf("rel_irdy%0d", k), 32'(irdy[k]), 1);
    next();

    // Streaming 0x01..0x10 with the output always ready
    out_ready = 1'b1;
    nout = 0;
    for (int j = 0; j < 22; j++) begin
      in_valid = (j < 16);
      in_data  = 8'(j + 1);
      sample();
      if (j < 16) chk("stream_irdy", 32'(irdy[0]), 1);
      chk("stream_ovld", 32'(ovld[0]), 32'(j >= 3 && j < 19));
      if (ovld[0]) begin
        chk("stream_data", 32'(odat[0]), nout + 1);
        nout++;
      end
      if (j <= 16) chk("stream_occ", 32'(occw[0]), (j < 3) ? j : 3);
      next();
    end
    chk("stream_count", nout, 16);

    // Backpressure from empty: exactly CAP beats get in
    out_ready = 1'b0;
    nin = 0;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + j);
      sample();
      if (irdy[0]) nin++;
      next();
    end
    in_valid = 1'b0;
    sample();
    chk("bp_accepted", nin, 6);
    chk("bp_irdy", 32'(irdy[0]), 0);
    chk("bp_occ", 32'(occw[0]), 6);
    next();
    out_ready = 1'b1;
    nout = 0;
    for (int j = 0; j < 10; j++) begin
      sample();
      if (ovld[0]) begin
        chk("bp_data", 32'(odat[0]), 32'h20 + nout);
        nout++;
      end
      next();
    end
    chk("bp_out_count", nout, 6);
    sample();
    chk("bp_irdy_back", 32'(irdy[0]), 1);
    next();

    // Flush with four beats held
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + j);
      sample();
      next();
    end
    in_valid = 1'b0;
    sample();
    chk("fl_occ_before", 32'(occw[0]), 4);
    next();
    flush = 1'b1;
    sample();
    next();
    flush = 1'b0;
    sample();
    chk("fl_occ_after", 32'(occw[0]), 0);
    chk("fl_ovld_after", 32'(ovld[0]), 0);
    next();
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      sample();
      chk("fl_no_stale", 32'(ovld[0]), 0);
      next();
    end

    // Reset asserted between edges with five beats held
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + j);
      sample();
      next();
    end
    in_valid = 1'b0;
    sample();
    chk("rs_occ_before", 32'(occw[0]), 5);
    next();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rs_ovld%0d", k), 32'(ovld[k]), 0);
      chk($sformatf("rs_occ%0d", k), 32'(occw[k]), 0);
    end
    chk("rs_irdy", 32'(irdy[0]), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    sample();
    chk("rs_irdy_after", 32'(irdy[0]), 1);
    next();
    for (int j = 0; j < 8; j++) begin
      sample();
      chk("rs_no_stale", 32'(ovld[0]), 0);
      next();
    end

    // Single register stage: ready passes straight through from out_ready
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h70;
    sample();
    chk("k0_irdy_empty", 32'(irdy[1]), 1);
    next();
    in_data = 8'h71;
    sample();
    chk("k0_irdy_full", 32'(irdy[1]), 0);
    next();
    out_ready = 1'b1;
    in_data   = 8'h72;
    sample();
    chk("k0_irdy_pass", 32'(irdy[1]), 1);
    chk("k0_ovld", 32'(ovld[1]), 1);
    chk("k0_data", 32'(odat[1]), 32'h70);
    next();
    in_valid = 1'b0;
    sample();
    chk("k0_occ", 32'(occw[1]), 1);
    chk("k0_data2", 32'(odat[1]), 32'h72);
    next();
    idle(8);

    // Random valid / ready / flush until every configuration has taken 10000 beats
    for (int k = 0; k < 3; k++) nacc[k] = 0;
    orate = 70;
    vrate = 80;
    cyc = 0;
    while (cyc < 40000 && !(nacc[0] >= 10000 && nacc[1] >= 10000 && nacc[2] >= 10000)) begin
      if (cyc % 256 == 0) begin
        case ($urandom_range(0, 2))
          0:       orate = 25;
          1:       orate = 70;
          default: orate = 100;
        endcase
        vrate = ($urandom_range(0, 1) == 0) ? 50 : 95;
      end
      in_valid  = ($urandom_range(0, 99) < vrate);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < orate);
      flush     = ($urandom_range(0, 149) == 0);
      sample();
      next();
      cyc++;
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(12);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rand_beats%0d", k), 32'(nacc[k] >= 10000), 1);
      chk($sformatf("drain_empty%0d", k), sb_size(k), 0);
      chk($sformatf("drain_occ%0d", k), 32'(occw[k]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
